regfile_multiport: RTL and testbench

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

---
 rtl/regfile_multiport_if.sv | 29 ++
 rtl/regfile_multiport.sv | 110 +++++++++++
 tb/tb_regfile_multiport.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/regfile_multiport_if.sv
// rtl/regfile_multiport_if.sv - write/reserve/read bus of the multiport register file
// master drives writes, reserves and read addresses; slave returns read data, busy flags and ready.
interface regfile_multiport_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2
) ();
   localparam int AW = $clog2(NREG);

   logic                we;
   logic [AW-1:0]       waddr;
   logic [XLEN-1:0]     wdata;
   logic                rsv_en;
   logic [AW-1:0]       rsv_addr;
   logic [NRD*AW-1:0]   raddr;
   logic [NRD*XLEN-1:0] rdata;
   logic [NRD-1:0]      rbusy;
   logic                ready;

   modport master (
      output we, waddr, wdata, rsv_en, rsv_addr, raddr,
      input  rdata, rbusy, ready
   );

   modport slave (
      input  we, waddr, wdata, rsv_en, rsv_addr, raddr,
      output rdata, rbusy, ready
   );
endinterface

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multiport register file with pending scoreboard and post-reset clear sweep
// Optional macro REGFILE_MULTIPORT_BYPASS_EN forwards same-cycle write data onto the read ports.
module regfile_multiport #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2
) (
   input logic                clk,
   input logic                rst_n,
   regfile_multiport_if.slave bus
);
   localparam int AW = $clog2(NREG);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t          state_q;
   logic [AW-1:0]   cnt_q;
   logic            ready_q;
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [XLEN-1:0] regs_q [NREG];

   logic            wr_ok;
   logic            rsv_ok;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [XLEN-1:0] mem_data;

   assign wr_ok  = (state_q == RUN) && bus.we     && (bus.waddr    != '0);
   assign rsv_ok = (state_q == RUN) && bus.rsv_en && (bus.rsv_addr != '0);

   // Reserve is applied after the write-clear so it wins on a shared address.
   always_comb begin
      busy_d = busy_q;
      if (wr_ok)  busy_d[bus.waddr]    = 1'b0;
      if (rsv_ok) busy_d[bus.rsv_addr] = 1'b1;
   end

   always_comb begin
      mem_we   = 1'b0;
      mem_addr = bus.waddr;
      mem_data = bus.wdata;
      if (state_q == CLEAR) begin
         mem_we   = 1'b1;
         mem_addr = cnt_q;
         mem_data = '0;
      end else if (wr_ok) begin
         mem_we   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         cnt_q   <= AW'(1);
         ready_q <= 1'b0;
         busy_q  <= '0;
      end else begin
         case (state_q)
            CLEAR: begin
               cnt_q <= cnt_q + AW'(1);
               if (cnt_q == AW'(NREG - 1)) begin
                  state_q <= RUN;
                  ready_q <= 1'b1;
               end
            end
            RUN: begin
               busy_q <= busy_d;
            end
            default: begin
               state_q <= CLEAR;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Storage has no reset of its own; the sweep zeroes it.
   always_ff @(posedge clk) begin
      if (rst_n && mem_we) regs_q[mem_addr] <= mem_data;
   end

   assign bus.ready = ready_q;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] d;
      logic            b;

      assign ra = bus.raddr[k*AW +: AW];

      always_comb begin
         d = '0;
         b = 1'b0;
         if ((state_q == RUN) && (ra != '0)) begin
            d = regs_q[ra];
            b = busy_q[ra];
`ifdef REGFILE_MULTIPORT_BYPASS_EN
            if (wr_ok && (ra == bus.waddr)) begin
               d = bus.wdata;
               b = rsv_ok && (bus.rsv_addr == ra);
            end
`endif
         end
      end

      assign bus.rdata[k*XLEN +: XLEN] = d;
      assign bus.rbusy[k]              = b;
   end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - directed self-checking bench for regfile_multiport
module tb_regfile_multiport;
   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;
   int   n;

   always #5 clk = ~clk;

   regfile_multiport_if #(.XLEN(32), .NREG(32), .NRD(2)) bus ();

   regfile_multiport #(.XLEN(32), .NREG(32), .NRD(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.we     = 1'b0;
      bus.rsv_en = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.we       = 1'b1;
      bus.waddr    = 5'd5;
      bus.wdata    = 32'hDEADBEEF;
      bus.rsv_en   = 1'b0;
      bus.rsv_addr = 5'd0;
      bus.raddr    = {5'd5, 5'd5};

      repeat (3) tick();
      #1;
      check("rst_ready", 64'(bus.ready), 64'd0);
      check("rst_rbusy", 64'(bus.rbusy), 64'd0);
      check("rst_rdata", bus.rdata, 64'd0);

      rst_n = 1'b1;
      n = 0;
      while (!bus.ready && n < 40) begin
         tick();
         n++;
         if (n == 10) check("sweep_rdata", bus.rdata, 64'd0);
      end
      bus.we = 1'b0;
      #1;
      check("sweep_edges", 64'(n), 64'd31);
      check("clear_ignores_write", bus.rdata, 64'd0);

      bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h12345678;
      tick(); idle();
      bus.raddr = {5'd7, 5'd7};
      #1;
      check("wr7_rdata", bus.rdata, {32'h12345678, 32'h12345678});
      check("wr7_rbusy", 64'(bus.rbusy), 64'd0);

      bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF;
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
      tick(); idle();
      bus.raddr = {5'd7, 5'd0};
      #1;
      check("reg0_rdata", 64'(bus.rdata[31:0]), 64'd0);
      check("reg0_rbusy", 64'(bus.rbusy[0]), 64'd0);

      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
      tick(); idle();
      bus.raddr = {5'd3, 5'd3};
      #1;
      check("rsv3_rbusy", 64'(bus.rbusy), 64'd3);
      bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'hA5A5A5A5;
      tick(); idle();
      #1;
      check("wr3_rbusy", 64'(bus.rbusy), 64'd0);
      check("wr3_rdata", bus.rdata, {32'hA5A5A5A5, 32'hA5A5A5A5});
      bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'h11111111;
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
      tick(); idle();
      #1;
      check("wrrsv3_rbusy", 64'(bus.rbusy), 64'd3);
      check("wrrsv3_rdata", bus.rdata, {32'h11111111, 32'h11111111});

      bus.we = 1'b1; bus.waddr = 5'd6; bus.wdata = 32'h00000066;
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd8;
      tick(); idle();
      bus.raddr = {5'd8, 5'd6};
      #1;
      check("indep_rdata", bus.rdata, {32'h0, 32'h00000066});
      check("indep_rbusy", 64'(bus.rbusy), 64'd2);

      bus.raddr = {5'd9, 5'd9};
      bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'hCAFEF00D;
      #1;
`ifdef REGFILE_MULTIPORT_BYPASS_EN
      check("byp9_rdata", bus.rdata, {32'hCAFEF00D, 32'hCAFEF00D});
`else
      check("byp9_rdata", bus.rdata, 64'd0);
`endif
      check("byp9_rbusy", 64'(bus.rbusy), 64'd0);
      tick(); idle();
      #1;
      check("wr9_rdata", bus.rdata, {32'hCAFEF00D, 32'hCAFEF00D});

      bus.raddr = {5'd10, 5'd10};
      bus.we = 1'b1; bus.waddr = 5'd10; bus.wdata = 32'h0000BEEF;
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd10;
      #1;
`ifdef REGFILE_MULTIPORT_BYPASS_EN
      check("byp10_rdata", bus.rdata, {32'h0000BEEF, 32'h0000BEEF});
      check("byp10_rbusy", 64'(bus.rbusy), 64'd3);
`else
      check("byp10_rdata", bus.rdata, 64'd0);
      check("byp10_rbusy", 64'(bus.rbusy), 64'd0);
`endif
      tick(); idle();
      #1;
      check("wrrsv10_rbusy", 64'(bus.rbusy), 64'd3);
      check("wrrsv10_rdata", bus.rdata, {32'h0000BEEF, 32'h0000BEEF});

      bus.we = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h00000044;
      tick(); idle();
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4;
      tick(); idle();
      bus.raddr = {5'd3, 5'd4};
      #1;
      check("pre_rst_rbusy", 64'(bus.rbusy), 64'd3);
      check("pre_rst_rdata", 64'(bus.rdata[31:0]), 64'h44);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      check("midrst_ready", 64'(bus.ready), 64'd0);
      check("midrst_rbusy", 64'(bus.rbusy), 64'd0);
      n = 0;
      while (!bus.ready && n < 40) begin
         tick();
         n++;
      end
      #1;
      check("resweep_edges", 64'(n), 64'd31);
      check("resweep_rdata", bus.rdata, 64'd0);
      check("resweep_rbusy", 64'(bus.rbusy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
